// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and buffers {pc, word} pairs for IF/ID.
// Optional HALT handling is compiled in with `define FETCH_HALT_EN.
//
// state | meaning
// RUN   | fetching; buffer has room
// FULL  | buffer holds BUF_DEPTH entries; fetch paused until a pop
// HALT  | HALT word fetched; fetch frozen until redirect or reset
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        take,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] imemaddr_if,
  output logic [31:0] imemload_if,
  output logic [31:0] npc_if,
  output logic        halted
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);
  localparam logic [1:0] LAST    = 2'(BUF_DEPTH - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  rd_q, rd_d;
  logic [1:0]  wr_q, wr_d;
  // Storage sized for the largest legal depth so pointer widths stay fixed.
  logic [31:0] pcb_q [4];
  logic [31:0] wb_q  [4];

  logic push, pop;
  logic unused_rpc_lsbs;

  assign unused_rpc_lsbs = &{1'b0, redirect_pc[1:0]};

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign imemaddr    = pc_q;
  assign imemREN     = nRST && (state_q == ST_RUN) && !redirect;
  assign inst_valid  = (count_q != 3'd0);
  assign imemaddr_if = inst_valid ? pcb_q[rd_q] : 32'h0;
  assign imemload_if = inst_valid ? wb_q[rd_q]  : 32'h0;
  assign npc_if      = imemaddr_if + 32'd4;

  assign push = imemREN && ihit;
  assign pop  = take && inst_valid;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    if (redirect) begin
      state_d = ST_RUN;
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 3'd0;
      rd_d    = 2'd0;
      wr_d    = 2'd0;
`ifdef FETCH_HALT_EN
      halted_d = 1'b0;
`endif
    end else begin
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push) begin
        wr_d = ptr_inc(wr_q);
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
      case (state_q)
        ST_RUN:  if (push && !pop && (count_q == DEPTH_C - 3'd1)) state_d = ST_FULL;
        ST_FULL: if (pop) state_d = ST_RUN;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
`ifdef FETCH_HALT_EN
      // HALT is buffered like any word but freezes fetch behind it.
      if (push && (imemload == 32'hFFFF_FFFF)) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
      count_q <= 3'd0;
      rd_q    <= 2'd0;
      wr_q    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        pcb_q[i] <= 32'h0;
        wb_q[i]  <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push && !redirect) begin
        pcb_q[wr_q] <= pc_q;
        wb_q[wr_q]  <= imemload;
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random run vs a queue model.
module tb_fetch_unit;

  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        take = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] imemaddr_if;
  logic [31:0] imemload_if;
  logic [31:0] npc_if;
  logic        halted;

  fetch_unit #(.PC_RESET(PC_RESET), .BUF_DEPTH(BUF_DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .take(take), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .imemaddr_if(imemaddr_if),
    .imemload_if(imemload_if), .npc_if(npc_if), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          halt_at8 = 0;

  typedef struct {
    logic ren; logic [31:0] addr; logic valid; logic [31:0] if_addr;
    logic [31:0] npc; logic halted;
  } smp_t;

  typedef struct {
    bit rst; bit ih; bit tk; bit rd; logic [31:0] rpc;
    bit ren; logic [31:0] addr; bit valid; logic [31:0] if_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_at8 && a == 32'h8) return 32'hFFFF_FFFF;
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  task automatic do_reset();
    nRST = 1'b0; ihit = 0; take = 0; redirect = 0;
    #1;
    chk("rst_ren", imemREN, 0);
    chk("rst_addr", imemaddr, PC_RESET);
    chk("rst_valid", inst_valid, 0);
    chk("rst_if_addr", imemaddr_if, 0);
    chk("rst_if_load", imemload_if, 0);
    chk("rst_npc", npc_if, 32'h4);
    chk("rst_halted", halted, 0);
    @(negedge CLK);
    nRST = 1'b1;
    mq.delete(); m_pc = PC_RESET; m_halt = 0;
    @(posedge CLK); #1;
  endtask

  // One cycle: drive, sample at negedge against the model, advance the model, step past posedge.
  task automatic step(input bit ih, input bit tk, input bit rd, input logic [31:0] rpc,
                      input logic [31:0] ld, output smp_t s);
    bit e_ren, pop, push;
    logic [31:0] e_ifa, e_ifl;
    ihit = ih; take = tk; redirect = rd; redirect_pc = rpc; imemload = ld;
    @(negedge CLK);
    s = '{imemREN, imemaddr, inst_valid, imemaddr_if, npc_if, halted};
    e_ren = !m_halt && (mq.size() < BUF_DEPTH) && !rd;
    e_ifa = (mq.size() > 0) ? mq[0].pc : 32'h0;
    e_ifl = (mq.size() > 0) ? mq[0].word : 32'h0;
    chk("m_ren", imemREN, e_ren);
    chk("m_addr", imemaddr, m_pc);
    chk("m_valid", inst_valid, mq.size() > 0);
    chk("m_if_addr", imemaddr_if, e_ifa);
    chk("m_if_load", imemload_if, e_ifl);
    chk("m_npc", npc_if, e_ifa + 32'd4);
    chk("m_halted", halted, m_halt);
    if (rd) begin
      mq.delete(); m_pc = {rpc[31:2], 2'b00}; m_halt = 0;
    end else begin
      pop  = tk && (mq.size() > 0);
      push = e_ren && ih;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{m_pc, ld});
        m_pc = m_pc + 32'd4;
`ifdef FETCH_HALT_EN
        if (ld == 32'hFFFF_FFFF) m_halt = 1;
`endif
      end
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    smp_t s;
    // steady stream
    vecs.push_back('{1,1,1,0,0, 1,32'h0, 0,32'h0});
    vecs.push_back('{0,1,1,0,0, 1,32'h4, 1,32'h0});
    vecs.push_back('{0,1,1,0,0, 1,32'h8, 1,32'h4});
    vecs.push_back('{0,1,1,0,0, 1,32'hC, 1,32'h8});
    // stall until full, then drain
    vecs.push_back('{1,1,0,0,0, 1,32'h0, 0,32'h0});
    vecs.push_back('{0,1,0,0,0, 1,32'h4, 1,32'h0});
    vecs.push_back('{0,1,0,0,0, 0,32'h8, 1,32'h0});
    vecs.push_back('{0,1,0,0,0, 0,32'h8, 1,32'h0});
    vecs.push_back('{0,1,1,0,0, 0,32'h8, 1,32'h0});
    vecs.push_back('{0,1,1,0,0, 1,32'h8, 1,32'h4});
    vecs.push_back('{0,1,1,0,0, 1,32'hC, 1,32'h8});
    // miss at 0x10
    vecs.push_back('{1,0,0,1,32'h10, 0,32'h0, 0,32'h0});
    vecs.push_back('{0,0,0,0,0, 1,32'h10, 0,32'h0});
    vecs.push_back('{0,0,0,0,0, 1,32'h10, 0,32'h0});
    vecs.push_back('{0,0,0,0,0, 1,32'h10, 0,32'h0});
    vecs.push_back('{0,1,0,0,0, 1,32'h10, 0,32'h0});
    vecs.push_back('{0,0,1,0,0, 1,32'h14, 1,32'h10});
    vecs.push_back('{0,0,0,0,0, 1,32'h14, 0,32'h0});

    #2;
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].ih, vecs[i].tk, vecs[i].rd, vecs[i].rpc, mem_word(m_pc), s);
      chk($sformatf("tbl%0d_ren", i), s.ren, vecs[i].ren);
      chk($sformatf("tbl%0d_addr", i), s.addr, vecs[i].addr);
      chk($sformatf("tbl%0d_valid", i), s.valid, vecs[i].valid);
      chk($sformatf("tbl%0d_if_addr", i), s.if_addr, vecs[i].if_addr);
    end

    // redirect with same-cycle hit and take while full
    do_reset();
    step(0, 0, 1, 32'h20, 0, s);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    step(1, 1, 1, 32'h103, mem_word(m_pc), s);
    chk("redir_pre_head", s.if_addr, 32'h20);
    chk("redir_pre_ren", s.ren, 0);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    chk("redir_valid", s.valid, 0);
    chk("redir_pc", s.addr, 32'h100);
    chk("redir_ren", s.ren, 1);
    step(0, 0, 0, 0, 0, s);
    chk("redir_head", s.if_addr, 32'h100);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 0, s);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    chk("wrap_addr_pre", s.addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, s);
    chk("wrap_addr", s.addr, 32'h0);
    chk("wrap_if_addr", s.if_addr, 32'hFFFF_FFFC);
    chk("wrap_npc", s.npc, 32'h0);

    // back-to-back redirects
    step(0, 0, 1, 32'h200, 0, s);
    step(1, 1, 1, 32'h300, 32'h1234, s);
    step(0, 0, 0, 0, 0, s);
    chk("b2b_addr", s.addr, 32'h300);
    chk("b2b_valid", s.valid, 0);

    // reset in the middle of a miss
    step(0, 0, 0, 0, 0, s);
    do_reset();
    step(0, 0, 0, 0, 0, s);
    chk("rstmiss_addr", s.addr, PC_RESET);
    chk("rstmiss_ren", s.ren, 1);

`ifdef FETCH_HALT_EN
    do_reset();
    halt_at8 = 1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, mem_word(m_pc), s);
    step(1, 1, 0, 0, mem_word(m_pc), s);
    chk("halt_flag", s.halted, 1);
    chk("halt_ren", s.ren, 0);
    chk("halt_pc", s.addr, 32'hC);
    chk("halt_head", s.if_addr, 32'h8);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    chk("halt_drained", s.valid, 0);
    chk("halt_pc_frozen", s.addr, 32'hC);
    step(0, 0, 1, 32'h40, 0, s);
    step(1, 0, 0, 0, mem_word(m_pc), s);
    chk("halt_exit_flag", s.halted, 0);
    chk("halt_exit_pc", s.addr, 32'h40);
    chk("halt_exit_ren", s.ren, 1);
    halt_at8 = 0;
`endif

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom, ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFF : $urandom, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
